// File: rtl/router_reg_gen.sv
// -----------------------------------------------------------------------------
// router_reg_gen
//   Datapath register block for a packet router. It captures the header,
//   drives bytes to the output FIFO, buffers one byte while the FIFO is full,
//   accumulates running parity and payload length, and checks both against
//   the trailing parity byte and the header length field.
//
// Ports
//   clock, resetn        : rising-edge clock, asynchronous active-low reset
//   pkt_valid, data_in   : source byte stream
//   fifo_full            : destination FIFO back-pressure
//   detect_add .. rst_int_reg : one-hot-ish decodes from the router FSM
//   dout                 : registered byte to FIFO
//   parity_done          : packet parity byte has been captured
//   low_pkt_valid        : source has dropped pkt_valid (end of packet seen)
//   err / len_err        : parity / length mismatch for the current packet
//   err_count            : saturating count of errored packets
// -----------------------------------------------------------------------------
module router_reg_gen #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              rst_int_reg,
    output logic [DATA_W-1:0] dout,
    output logic              parity_done,
    output logic              low_pkt_valid,
    output logic              err,
    output logic              len_err,
    output logic [CNT_W-1:0]  err_count
);

    localparam int LEN_W = DATA_W - ADDR_W;

    logic [DATA_W-1:0] hdr_q,     hdr_d;
    logic [DATA_W-1:0] hold_q,    hold_d;
    logic [DATA_W-1:0] dout_q,    dout_d;
    logic [DATA_W-1:0] int_par_q, int_par_d;
    logic [DATA_W-1:0] pkt_par_q, pkt_par_d;
    logic [LEN_W:0]    cnt_q,     cnt_d;
    logic              pdone_q,   pdone_d;
    logic              pdone_dly_q;
    logic              lpv_q,     lpv_d;
    logic              err_q,     err_d;
    logic              len_err_q, len_err_d;
    logic [CNT_W-1:0]  ecnt_q,    ecnt_d;

    logic hdr_ok, byte_acc, par_ld, chk, par_mis, len_mis;

    always_comb begin
        // A header addressed to the all-ones port is not a valid destination,
        // so the previously captured header is kept.
        hdr_ok   = detect_add && pkt_valid && (data_in[ADDR_W-1:0] != '1);
        byte_acc = ld_state && pkt_valid && !full_state;
        // Parity byte arrives either directly, or was stranded while the FIFO
        // was full and is picked up again in the load-after-full state.
        par_ld   = (ld_state && !pkt_valid && !fifo_full) ||
                   (laf_state && lpv_q && !pdone_q);
        // Check fires in the first cycle parity_done is visible high.
        chk      = pdone_q && !pdone_dly_q;
        par_mis  = (int_par_q != pkt_par_q);
        len_mis  = (cnt_q != {1'b0, hdr_q[DATA_W-1:ADDR_W]});

        hdr_d     = hdr_ok ? data_in : hdr_q;
        hold_d    = (ld_state && fifo_full) ? data_in : hold_q;

        dout_d = dout_q;
        if (lfd_state)                    dout_d = hdr_q;
        else if (ld_state && !fifo_full)  dout_d = data_in;
        else if (laf_state)               dout_d = hold_q;

        int_par_d = int_par_q;
        if (detect_add)     int_par_d = '0;
        else if (lfd_state) int_par_d = int_par_q ^ hdr_q;
        else if (byte_acc)  int_par_d = int_par_q ^ data_in;

        cnt_d = cnt_q;
        if (detect_add)
            cnt_d = '0;
        else if (byte_acc && (cnt_q != {(LEN_W+1){1'b1}}))
            cnt_d = cnt_q + (LEN_W+1)'(1);

        pkt_par_d = par_ld ? data_in : pkt_par_q;

        pdone_d = pdone_q;
        if (detect_add)  pdone_d = 1'b0;
        else if (par_ld) pdone_d = 1'b1;

        lpv_d = lpv_q;
        if (rst_int_reg)                 lpv_d = 1'b0;
        else if (ld_state && !pkt_valid) lpv_d = 1'b1;

        err_d     = err_q;
        len_err_d = len_err_q;
        ecnt_d    = ecnt_q;
        if (detect_add) begin
            err_d     = 1'b0;
            len_err_d = 1'b0;
        end else if (chk) begin
            err_d     = err_q | par_mis;
            len_err_d = len_err_q | len_mis;
            if ((par_mis || len_mis) && (ecnt_q != {CNT_W{1'b1}}))
                ecnt_d = ecnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hdr_q       <= '0;
            hold_q      <= '0;
            dout_q      <= '0;
            int_par_q   <= '0;
            pkt_par_q   <= '0;
            cnt_q       <= '0;
            pdone_q     <= 1'b0;
            pdone_dly_q <= 1'b0;
            lpv_q       <= 1'b0;
            err_q       <= 1'b0;
            len_err_q   <= 1'b0;
            ecnt_q      <= '0;
        end else begin
            hdr_q       <= hdr_d;
            hold_q      <= hold_d;
            dout_q      <= dout_d;
            int_par_q   <= int_par_d;
            pkt_par_q   <= pkt_par_d;
            cnt_q       <= cnt_d;
            pdone_q     <= pdone_d;
            pdone_dly_q <= pdone_q;
            lpv_q       <= lpv_d;
            err_q       <= err_d;
            len_err_q   <= len_err_d;
            ecnt_q      <= ecnt_d;
        end
    end

    assign dout          = dout_q;
    assign parity_done   = pdone_q;
    assign low_pkt_valid = lpv_q;
    assign err           = err_q;
    assign len_err       = len_err_q;
    assign err_count     = ecnt_q;

endmodule
